// File: rtl/fifo_stream_reader_pkg.sv
// Types and constants shared by the FIFO stream reader, its output buffer and its interface.
`include "fifo_defs.sv"

package fifo_stream_reader_pkg;

   localparam int BWIDTH_DEF = `FIFO_BWIDTH;
   localparam int CNTW_DEF   = `FIFO_CNTW;
   localparam int RD_LATENCY = `FIFO_RD_LATENCY;
   localparam int BUF_DEPTH  = 2;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      STREAM
   } state_t;

   // Buffered words outrank an outstanding read when naming the state.
   function automatic state_t nextState(input logic [2:0] occ, input logic readIssued);
      if (occ != 3'd0) begin
         return STREAM;
      end
      if (readIssued) begin
         return FETCH;
      end
      return IDLE;
   endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus downstream valid/ready stream; master is the reader, slave the environment.
interface fifo_stream_reader_if #(
   parameter int BWIDTH = fifo_stream_reader_pkg::BWIDTH_DEF,
   parameter int CNTW   = fifo_stream_reader_pkg::CNTW_DEF
) ();

   logic              en;
   logic              fifo_empty;
   logic [BWIDTH-1:0] fifo_r_data;
   logic              fifo_r_en;
   logic              m_valid;
   logic              m_ready;
   logic [BWIDTH-1:0] m_data;
   logic [CNTW-1:0]   m_count;

   modport master (
      input  en,
      input  fifo_empty,
      input  fifo_r_data,
      input  m_ready,
      output fifo_r_en,
      output m_valid,
      output m_data,
      output m_count
   );

   modport slave (
      output en,
      output fifo_empty,
      output fifo_r_data,
      output m_ready,
      input  fifo_r_en,
      input  m_valid,
      input  m_data,
      input  m_count
   );

endinterface

// File: rtl/fifo_defs.sv
// Shared FIFO build constants, included by both the stream reader and the FIFO RAM.
// Guarded so the file can appear in a file list and still be included elsewhere.
`ifndef FIFO_DEFS_SV
`define FIFO_DEFS_SV

`define FIFO_BWIDTH     8
`define FIFO_CNTW       16
`define FIFO_RD_LATENCY 1

`endif

// File: rtl/fifo_out_buf.sv
// Two-entry in-order output buffer; data_o always presents the oldest word.
module fifo_out_buf
   import fifo_stream_reader_pkg::*;
#(
   parameter int BWIDTH = BWIDTH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [BWIDTH-1:0] data_i,
   output logic [BWIDTH-1:0] data_o,
   output logic [1:0]        occ_o
);

   logic [BWIDTH-1:0] head_q, head_d;
   logic [BWIDTH-1:0] tail_q, tail_d;
   logic [1:0]        occ_q, occ_d;
   logic              doPop;
   logic              doPush;

   // A simultaneous push and pop keeps occupancy; the new word lands behind whatever remains.
   always_comb begin
      doPop  = pop_i && (occ_q != 2'd0);
      doPush = push_i && ((occ_q != 2'd2) || doPop);
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      case ({doPush, doPop})
         2'b10: begin
            if (occ_q == 2'd0) begin
               head_d = data_i;
            end else begin
               tail_d = data_i;
            end
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            head_d = tail_q;
            occ_d  = occ_q - 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd1) begin
               head_d = data_i;
            end else begin
               head_d = tail_q;
               tail_d = data_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= 2'd0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   assign data_o = head_q;
   assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pulls words from a 1-cycle-latency FIFO and streams them out over valid/ready at up to
// one word per cycle, counting delivered words.
module fifo_stream_reader
   import fifo_stream_reader_pkg::*;
#(
   parameter int BWIDTH = BWIDTH_DEF,
   parameter int CNTW   = CNTW_DEF
) (
   input logic                  clk,
   input logic                  rst_n,
   fifo_stream_reader_if.master bus
);

   state_t            state_q, state_d;
   logic              inflight_q, inflight_d;
   logic              armed_q;
   logic [CNTW-1:0]   count_q, count_d;
   logic [1:0]        bufOcc;
   logic [BWIDTH-1:0] bufData;
   logic              pop;
   logic              readEn;
   logic [2:0]        occNext;

   assign pop = (state_q == STREAM) && bus.m_ready;

   // occNext is the buffer fill after this edge; a read may only go out if its word will fit.
   always_comb begin
      occNext    = {1'b0, bufOcc} + {2'b00, inflight_q} - {2'b00, pop};
      readEn     = armed_q && bus.en && !bus.fifo_empty &&
                   ((occNext + 3'(RD_LATENCY)) <= 3'(BUF_DEPTH));
      inflight_d = readEn;
      state_d    = nextState(occNext, readEn);
      count_d    = pop ? count_q + CNTW'(1) : count_q;
   end

   fifo_out_buf #(
      .BWIDTH (BWIDTH)
   ) u_buf (
      .clk    (clk),
      .rst_n  (rst_n),
      .push_i (inflight_q),
      .pop_i  (pop),
      .data_i (bus.fifo_r_data),
      .data_o (bufData),
      .occ_o  (bufOcc)
   );

   // armed_q holds off reads for the first cycle out of reset; clearing inflight_q drops any
   // word that was on its way back when reset hit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         inflight_q <= 1'b0;
         armed_q    <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         inflight_q <= inflight_d;
         armed_q    <= 1'b1;
         count_q    <= count_d;
      end
   end

   assign bus.fifo_r_en = readEn;
   assign bus.m_valid   = (state_q == STREAM);
   assign bus.m_data    = bufData;
   assign bus.m_count   = count_q;

endmodule
